// File: rtl/strobe_src.sv
// Strobe producer: divides clk into periodic one-cycle ticks and drives them onto
// LANES consumer lanes, broadcast or round-robin, for a configured number of periods.

module strobe_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic fire,
    input  logic en,
    output logic tick
);
    always_ff @(posedge clk) begin
        if (!rst_n) tick <= 1'b0;
        else        tick <= fire & en;
    end
endmodule

module strobe_src #(
    parameter int LANES = 2,
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [LANES-1:0] cfg_mask,
    input  logic             cfg_rr,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             stop,
    output logic [LANES-1:0] tick,
    output logic             busy,
    output logic             done
);
    localparam int PW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW1 = PW + 1;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [LANES-1:0] mask;
        logic             rr;
        logic [CNT_W-1:0] count;
    } cfg_t;

    state_t           state;
    cfg_t             cfg;
    logic [DIV_W-1:0] cnt;
    logic [CNT_W-1:0] left;
    logic [PW-1:0]    ptr;
    logic             period_end;

    logic [LANES-1:0] rr_sel;
    logic [PW-1:0]    nxt_ptr;
    logic             hit;
    logic [PW1-1:0]   idx;
    logic [PW1-1:0]   nidx;

    assign period_end = (state == RUN) && (cnt == cfg.div);
    assign cfg_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    // First enabled lane at or after ptr, wrapping; ptr then moves just past it.
    always_comb begin
        rr_sel  = '0;
        nxt_ptr = ptr;
        hit     = 1'b0;
        idx     = '0;
        nidx    = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = {1'b0, ptr} + PW1'(k);
            if (idx >= PW1'(LANES)) idx = idx - PW1'(LANES);
            if (!hit && cfg.mask[idx[PW-1:0]]) begin
                hit                 = 1'b1;
                rr_sel[idx[PW-1:0]] = 1'b1;
                nidx                = idx + PW1'(1);
                nxt_ptr             = (nidx == PW1'(LANES)) ? '0 : nidx[PW-1:0];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        strobe_lane u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .fire (period_end),
            .en   (cfg.rr ? rr_sel[i] : cfg.mask[i]),
            .tick (tick[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cfg   <= '0;
            cnt   <= '0;
            left  <= '0;
            ptr   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    cfg.div   <= cfg_div;
                    cfg.mask  <= cfg_mask;
                    cfg.rr    <= cfg_rr;
                    cfg.count <= cfg_count;
                    state     <= ARM;
                end
                ARM: begin
                    cnt  <= '0;
                    left <= cfg.count;
                    if (stop) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: if (cnt == cfg.div) begin
                    cnt <= '0;
                    if (cfg.rr && hit) ptr <= nxt_ptr;
                    if (left != '0) left <= left - CNT_W'(1);
                    // Final tick goes out with done; the run is over in that same cycle.
                    if (stop || (cfg.count != '0 && left == CNT_W'(1))) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_strobe_src.sv
// Bench for strobe_src: directed and random runs checked cycle by cycle against a
// period-arithmetic model of tick, done, busy and cfg_ready.

module tb_strobe_src;
    localparam int L  = 3;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_rr = 1'b0;
    logic          stop = 1'b0;
    logic [DW-1:0] cfg_div = '0;
    logic [L-1:0]  cfg_mask = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          cfg_ready, busy, done;
    logic [L-1:0]  tick;

    int vectors = 0;
    int miscompares = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    strobe_src #(.LANES(L), .DIV_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .cfg_mask (cfg_mask),
        .cfg_rr   (cfg_rr),
        .cfg_count(cfg_count),
        .stop     (stop),
        .tick     (tick),
        .busy     (busy),
        .done     (done)
    );

    // One run, handshake in cycle 0. stop_at<0: stop never raised; otherwise stop is
    // held high from that cycle until the run ends. junk: offer a bogus config while busy.
    task automatic run_case(input string name, input int div, input logic [L-1:0] mask,
                            input bit rr, input int count, input int stop_at, input bit junk);
        int per, e, kmax, l, k;
        logic [L-1:0] et;
        logic ebusy;
        per = div + 1;
        e = 0;
        kmax = 0;
        if (stop_at >= 0 && stop_at <= 1) e = 2;
        else begin
            for (int kk = 1; e == 0 && kk < 100000; kk++)
                if ((count != 0 && kk == count) || (stop_at >= 0 && 1 + kk * per >= stop_at)) begin
                    kmax = kk;
                    e = 2 + kk * per;
                end
        end
        for (int c = 0; c <= e + 1; c++) begin
            @(negedge clk);
            et = '0;
            k = (c - 2) / per;
            if (c >= 2 && (c - 2) % per == 0 && k >= 1 && k <= kmax) begin
                if (!rr) et = mask;
                else if (mask != '0) begin
                    l = -1;
                    for (int j = 0; j < L; j++)
                        if (l < 0 && mask[(m_ptr + j) % L]) l = (m_ptr + j) % L;
                    et = L'(1) << l;
                    m_ptr = (l + 1) % L;
                end
            end
            ebusy = (c >= 1 && c < e);
            vectors++;
            if (tick !== et) begin
                miscompares++;
                $display("FAIL %s tick c%0d got %b want %b", name, c, tick, et);
            end
            vectors++;
            if (done !== (c == e)) begin
                miscompares++;
                $display("FAIL %s done c%0d got %b want %b", name, c, done, (c == e));
            end
            vectors++;
            if (busy !== ebusy) begin
                miscompares++;
                $display("FAIL %s busy c%0d got %b want %b", name, c, busy, ebusy);
            end
            vectors++;
            if (cfg_ready !== !ebusy) begin
                miscompares++;
                $display("FAIL %s cfg_ready c%0d got %b want %b", name, c, cfg_ready, !ebusy);
            end
            cfg_valid = (c == 0) || (junk && c >= 1 && c < e);
            stop = (stop_at >= 0 && c >= stop_at && c < e);
            if (c == 0) begin
                cfg_div   = DW'(div);
                cfg_mask  = mask;
                cfg_rr    = rr;
                cfg_count = CW'(count);
            end else begin
                cfg_div   = DW'($urandom);
                cfg_mask  = L'($urandom);
                cfg_rr    = 1'($urandom);
                cfg_count = CW'($urandom_range(1, 9));
            end
        end
        cfg_valid = 1'b0;
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (tick !== '0 || done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset got tick=%b done=%b busy=%b rdy=%b want 000 0 0 1",
                     tick, done, busy, cfg_ready);
        end
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_broadcast();
        run_case("t1_bcast", 3, 3'b011, 1'b0, 2, -1, 1'b0);
        run_case("bcast_div0", 0, 3'b111, 1'b0, 3, -1, 1'b0);
        run_case("bcast_divmax", 255, 3'b101, 1'b0, 1, -1, 1'b0);
    endtask

    task automatic test_round_robin();
        run_case("t2_rr", 0, 3'b101, 1'b1, 4, -1, 1'b0);
        run_case("rr_single", 2, 3'b010, 1'b1, 3, -1, 1'b0);
        run_case("rr_all", 1, 3'b111, 1'b1, 5, -1, 1'b0);
    endtask

    task automatic test_stop();
        run_case("t3_stop", 4, 3'b110, 1'b0, 0, 9, 1'b0);
        run_case("stop_and_expire", 2, 3'b011, 1'b0, 2, 7, 1'b0);
    endtask

    task automatic test_mask_zero();
        run_case("t4_mask0", 1, 3'b000, 1'b0, 3, -1, 1'b0);
        run_case("mask0_rr", 0, 3'b000, 1'b1, 2, -1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 3) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL t5_busy got %b want 1", busy);
                end
            end
            if (c == 6) begin
                vectors++;
                if (tick !== '0 || done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL t5_reset got tick=%b done=%b rdy=%b busy=%b want 000 0 1 0",
                             tick, done, cfg_ready, busy);
                end
            end
            cfg_valid = (c == 0);
            cfg_div   = 8'd3;
            cfg_mask  = 3'b011;
            cfg_rr    = 1'b0;
            cfg_count = 16'd2;
            rst_n     = (c != 5);
        end
        cfg_valid = 1'b0;
        m_ptr = 0;
        run_case("t5_after", 3, 3'b011, 1'b0, 2, -1, 1'b0);
    endtask

    task automatic test_arm_stop_and_busy_cfg();
        run_case("t6_arm_stop", 2, 3'b111, 1'b0, 3, 1, 1'b1);
        run_case("t6_busy_cfg", 2, 3'b110, 1'b1, 4, -1, 1'b1);
    endtask

    task automatic test_random();
        int div, count, stop_at, per;
        for (int n = 0; n < 24; n++) begin
            div = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 5);
            per = div + 1;
            count = $urandom_range(0, 4);
            if (count == 0) stop_at = $urandom_range(0, 3 * per + 3);
            else if ($urandom_range(0, 2) == 0) stop_at = $urandom_range(0, count * per + 3);
            else stop_at = -1;
            run_case("random", div, L'($urandom), 1'($urandom), count, stop_at, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_round_robin();
        test_stop();
        test_mask_zero();
        test_reset_mid_run();
        test_arm_stop_and_busy_cfg();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
